nios_mul_pipe_unit: RTL and testbench

//  Parametrised, pipelined integer multiplier for the Nios II custom CPU datapath; successor to the

---
 rtl/nios_mul_pkg.sv | 11 +
 rtl/nios_mul_half_cell.sv | 32 +++
 rtl/nios_mul_pipe_unit.sv | 105 ++++++++++
 tb/tb_nios_mul_pipe_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mul_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: op encoding and pipeline depth.
package nios_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  localparam int MUL_LATENCY = 2;

endpackage

// File: rtl/nios_mul_half_cell.sv
// Registered unsigned HALF_W x HALF_W multiplier; one DSP-sized partial product.
module nios_mul_half_cell #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic [2*HALF_W-1:0]   p
);

  logic [2*HALF_W-1:0] p_d, p_q;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/nios_mul_pipe_unit.sv
// Two-stage pipelined multiplier: S1 forms four unsigned partial products plus signed corrections,
// S2 sums them and selects the low word or the corrected high word.
module nios_mul_pipe_unit
  import nios_mul_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic [1:0]        E_op,
  input  logic              E_valid,
  input  logic              M_en,
  input  logic              flush,
  output logic [DATA_W-1:0] M_mul_result,
  output logic              M_mul_valid,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  if (((DATA_W % 2) != 0) || (DATA_W < 8)) begin : g_bad_data_w
    $error("nios_mul_pipe_unit: DATA_W must be even and >= 8");
  end

  logic [DATA_W-1:0] ll_p, lh_p, hl_p, hh_p;

  nios_mul_half_cell #(.HALF_W(HALF_W)) u_ll (
    .clk(clk), .reset_n(reset_n), .en(M_en),
    .a(E_src1[HALF_W-1:0]), .b(E_src2[HALF_W-1:0]), .p(ll_p)
  );
  nios_mul_half_cell #(.HALF_W(HALF_W)) u_lh (
    .clk(clk), .reset_n(reset_n), .en(M_en),
    .a(E_src1[HALF_W-1:0]), .b(E_src2[DATA_W-1:HALF_W]), .p(lh_p)
  );
  nios_mul_half_cell #(.HALF_W(HALF_W)) u_hl (
    .clk(clk), .reset_n(reset_n), .en(M_en),
    .a(E_src1[DATA_W-1:HALF_W]), .b(E_src2[HALF_W-1:0]), .p(hl_p)
  );
  nios_mul_half_cell #(.HALF_W(HALF_W)) u_hh (
    .clk(clk), .reset_n(reset_n), .en(M_en),
    .a(E_src1[DATA_W-1:HALF_W]), .b(E_src2[DATA_W-1:HALF_W]), .p(hh_p)
  );

  logic [1:0]             op_d, op_q;
  logic [DATA_W-1:0]      corra_d, corra_q;
  logic [DATA_W-1:0]      corrb_d, corrb_q;
  logic [DATA_W-1:0]      result_d, result_q;
  logic [MUL_LATENCY-1:0] vld_d, vld_q;
  logic [PROD_W-1:0]      p_full;
  logic [DATA_W-1:0]      hi_word;
  logic                   a_signed;

  always_comb begin
    op_d     = op_q;
    corra_d  = corra_q;
    corrb_d  = corrb_q;
    result_d = result_q;
    vld_d    = vld_q;

    p_full = {{DATA_W{1'b0}}, ll_p}
           + ({{DATA_W{1'b0}}, lh_p} << HALF_W)
           + ({{DATA_W{1'b0}}, hl_p} << HALF_W)
           + {hh_p, {DATA_W{1'b0}}};
    // Signed high word = unsigned high word minus the operand of each negative signed input.
    hi_word  = p_full[PROD_W-1:DATA_W] - corra_q - corrb_q;
    a_signed = !((E_op == OP_MUL) || (E_op == OP_MULXUU));

    if (M_en) begin
      op_d     = E_op;
      corra_d  = (a_signed && E_src1[DATA_W-1]) ? E_src2 : '0;
      corrb_d  = ((E_op == OP_MULXSS) && E_src2[DATA_W-1]) ? E_src1 : '0;
      result_d = (op_q == OP_MUL) ? p_full[DATA_W-1:0] : hi_word;
      vld_d    = {vld_q[MUL_LATENCY-2:0], E_valid};
    end

    // Flush kills every stage, including the operand arriving this cycle, even while stalled.
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      corra_q  <= '0;
      corrb_q  <= '0;
      result_q <= '0;
      vld_q    <= '0;
    end else begin
      op_q     <= op_d;
      corra_q  <= corra_d;
      corrb_q  <= corrb_d;
      result_q <= result_d;
      vld_q    <= vld_d;
    end
  end

  assign M_mul_result = result_q;
  assign M_mul_valid  = vld_q[MUL_LATENCY-1];
  assign busy         = |vld_q;

endmodule

// File: tb/tb_nios_mul_pipe_unit.sv
// Directed bench for nios_mul_pipe_unit (DATA_W=32) plus a random sweep of a DATA_W=16 instance.
module tb_nios_mul_pipe_unit;
  import nios_mul_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic        e_valid, m_en, flush;
  logic [31:0] res;
  logic        vld, busy;

  logic [15:0] a16, b16;
  logic [1:0]  op16;
  logic        e_valid16;
  logic [15:0] res16;
  logic        vld16, busy16;

  int n_pass  = 0;
  int n_total = 0;

  nios_mul_pipe_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .E_src1(a), .E_src2(b), .E_op(op),
    .E_valid(e_valid), .M_en(m_en), .flush(flush),
    .M_mul_result(res), .M_mul_valid(vld), .busy(busy)
  );

  nios_mul_pipe_unit #(.DATA_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .E_src1(a16), .E_src2(b16), .E_op(op16),
    .E_valid(e_valid16), .M_en(1'b1), .flush(1'b0),
    .M_mul_result(res16), .M_mul_valid(vld16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    else n_pass++;
  endtask

  // 16-bit reference via sign/zero extension to 32 bits (independent of the correction scheme)
  function automatic logic [15:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] o);
    logic [31:0] ex, ey, pr;
    ex = o[1] ? {{16{x[15]}}, x} : {16'h0, x};
    ey = (o == OP_MULXSS) ? {{16{y[15]}}, y} : {16'h0, y};
    pr = ex * ey;
    return (o == OP_MUL) ? pr[15:0] : pr[31:16];
  endfunction

  task automatic test_reset();
    #1;
    chk("reset_result", res, 32'h0);
    chk("reset_valid", {31'h0, vld}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    tick();
    tick();
    chk("reset_result16", {16'h0, res16}, 32'h0);
    chk("reset_valid16", {31'h0, vld16}, 32'h0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [4];
    logic [31:0] exp [4];
    ops = '{OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS};
    exp = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      e_valid = (i < 4);
      op      = (i < 4) ? ops[i] : OP_MUL;
      tick();
      if (i >= 1 && i <= 4) begin
        if (vld !== 1'b1)
          $display("FAIL b2b_valid[%0d]: got %0b expected 1", i - 1, vld);
        else if (res !== exp[i-1])
          $display("FAIL b2b_result[%0d]: got 0x%08h expected 0x%08h", i - 1, res, exp[i-1]);
        else n_pass++;
        n_total++;
      end
    end
    e_valid = 1'b0;
    chk("b2b_valid_drops", {31'h0, vld}, 32'h0);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                        output logic [31:0] r, output logic v);
    a = x; b = y; op = o; e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
    tick();
    r = res;
    v = vld;
  endtask

  task automatic test_signed_corners();
    logic [31:0] vec_a [6], vec_b [6], exp [6];
    logic [1:0]  vec_o [6];
    logic [31:0] r;
    logic        v;
    vec_a = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    vec_b = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
    vec_o = '{OP_MULXSS, OP_MULXUU, OP_MULXSU, OP_MUL, OP_MULXSS, OP_MULXUU};
    exp   = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'h0000_0004};
    for (int i = 0; i < 6; i++) begin
      run_op(vec_a[i], vec_b[i], vec_o[i], r, v);
      if (v !== 1'b1)
        $display("FAIL corner_valid[%0d]: got %0b expected 1", i, v);
      else if (r !== exp[i])
        $display("FAIL corner_result[%0d]: got 0x%08h expected 0x%08h", i, r, exp[i]);
      else n_pass++;
      n_total++;
    end
    tick();
  endtask

  task automatic test_stall();
    a = 32'd7; b = 32'd6; op = OP_MUL; e_valid = 1'b1; m_en = 1'b1;
    tick();
    e_valid = 1'b0; m_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_early_valid", {31'h0, vld}, 32'h0);
    end
    chk("stall_busy_held", {31'h0, busy}, 32'h1);
    m_en = 1'b1;
    tick();
    chk("stall_valid", {31'h0, vld}, 32'h1);
    chk("stall_result", res, 32'd42);
    m_en = 1'b0;
    a = 32'd100; b = 32'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_hold_valid", {31'h0, vld}, 32'h1);
      chk("stall_hold_result", res, 32'd42);
    end
    m_en = 1'b1;
    tick();
    chk("stall_release_valid", {31'h0, vld}, 32'h0);
  endtask

  task automatic test_flush();
    // Case A: one op in S1, a new E_valid in the flush cycle, pipeline running.
    a = 32'd3; b = 32'd4; op = OP_MUL; e_valid = 1'b1; m_en = 1'b1;
    tick();
    a = 32'd5; b = 32'd6; flush = 1'b1;
    tick();
    flush = 1'b0; e_valid = 1'b0;
    chk("flushA_busy", {31'h0, busy}, 32'h0);
    chk("flushA_valid", {31'h0, vld}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flushA_no_valid", {31'h0, vld}, 32'h0);
    end
    // Case B: result presented, another op in S1, flush while stalled with E_valid high.
    a = 32'd3; b = 32'd4; e_valid = 1'b1;
    tick();
    a = 32'd5; b = 32'd6;
    tick();
    chk("flushB_pre_result", res, 32'd12);
    m_en = 1'b0; flush = 1'b1; a = 32'd7; b = 32'd8;
    tick();
    flush = 1'b0; e_valid = 1'b0; m_en = 1'b1;
    chk("flushB_valid", {31'h0, vld}, 32'h0);
    chk("flushB_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flushB_no_valid", {31'h0, vld}, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    a = 32'd9; b = 32'd9; op = OP_MUL; e_valid = 1'b1; m_en = 1'b1;
    tick();
    a = 32'd2; b = 32'd2;
    tick();
    e_valid = 1'b0;
    chk("rstmid_pre_valid", {31'h0, vld}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_result", res, 32'h0);
    chk("rstmid_valid", {31'h0, vld}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_stale", {31'h0, vld}, 32'h0);
    end
    a = 32'd11; b = 32'd13; e_valid = 1'b1;
    tick();
    e_valid = 1'b0;
    chk("rstmid_lat1", {31'h0, vld}, 32'h0);
    tick();
    chk("rstmid_lat2_valid", {31'h0, vld}, 32'h1);
    chk("rstmid_lat2_result", res, 32'd143);
    tick();
  endtask

  task automatic test_sweep16();
    logic [15:0] prev_exp;
    logic        prev_v;
    logic [15:0] cur_exp;
    logic        cur_v;
    prev_exp = '0;
    prev_v   = 1'b0;
    for (int i = 0; i <= 10000; i++) begin
      if (i < 10000) begin
        a16       = 16'($urandom_range(0, 65535));
        b16       = 16'($urandom_range(0, 65535));
        op16      = 2'($urandom_range(0, 3));
        e_valid16 = ($urandom_range(0, 7) != 0);
      end else begin
        e_valid16 = 1'b0;
      end
      cur_exp = ref16(a16, b16, op16);
      cur_v   = e_valid16;
      tick();
      if (i >= 1) begin
        n_total++;
        if (vld16 !== prev_v)
          $display("FAIL sweep16_valid[%0d]: got %0b expected %0b", i - 1, vld16, prev_v);
        else if (prev_v && (res16 !== prev_exp))
          $display("FAIL sweep16_result[%0d]: got 0x%04h expected 0x%04h", i - 1, res16, prev_exp);
        else n_pass++;
      end
      prev_exp = cur_exp;
      prev_v   = cur_v;
    end
  endtask

  initial begin
    a = '0; b = '0; op = OP_MUL; e_valid = 1'b0; m_en = 1'b1; flush = 1'b0;
    a16 = '0; b16 = '0; op16 = OP_MUL; e_valid16 = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_signed_corners();
    test_stall();
    test_flush();
    test_reset_mid();
    test_sweep16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
